// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default sizes and
// the roles of the two write ports.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;
  // Write-port roles; the load port wins when both ports hit one register.
  localparam int WP_ALU     = 0;
  localparam int WP_LOAD    = 1;
  localparam int NWP        = 2;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets a bit, writeback clears it, and a set
// beats a clear in the same cycle. Register 0 is never busy.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [AW-1:0]     waddr0,
  input  logic              we1,
  input  logic [AW-1:0]     waddr1,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rbusy,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (we0)       busy_nxt[waddr0]   = 1'b0;
    if (we1)       busy_nxt[waddr1]   = 1'b0;
    // Applied after the clears so the newer producer keeps the register busy.
    if (iss_valid) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rbusy
    logic [AW-1:0] ra;
    logic          clr;
    assign ra  = raddr[k*AW +: AW];
    assign clr = (we0 && (waddr0 == ra)) || (we1 && (waddr1 == ra));
    assign rbusy[k] = !rst && busy[ra] && !clr;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports, NRD combinational read ports with
// write bypass, and a per-register busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [AW-1:0]         waddr0,
  input  logic [AW-1:0]         waddr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  output logic [NREGS-1:0]      busy_vec
);

  logic [DATA_W-1:0] mem [NREGS];

  logic              wen [NWP];
  logic [AW-1:0]     wa  [NWP];
  logic [DATA_W-1:0] wd  [NWP];

  assign wen[WP_ALU]  = we0;
  assign wa[WP_ALU]   = waddr0;
  assign wd[WP_ALU]   = wdata0;
  assign wen[WP_LOAD] = we1;
  assign wa[WP_LOAD]  = waddr1;
  assign wd[WP_LOAD]  = wdata1;

  // Load port written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (wen[WP_ALU] && (wa[WP_ALU] != '0))   mem[wa[WP_ALU]]  <= wd[WP_ALU];
      if (wen[WP_LOAD] && (wa[WP_LOAD] != '0)) mem[wa[WP_LOAD]] <= wd[WP_LOAD];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rd;
    assign ra = raddr[k*AW +: AW];
    always_comb begin
      rd = (ra == '0) ? '0 : mem[ra];
      if (wen[WP_ALU] && (wa[WP_ALU] == ra) && (ra != '0))   rd = wd[WP_ALU];
      if (wen[WP_LOAD] && (wa[WP_LOAD] == ra) && (ra != '0)) rd = wd[WP_LOAD];
    end
    assign rdata[k*DATA_W +: DATA_W] = rd;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .we0       (we0),
    .waddr0    (waddr0),
    .we1       (we1),
    .waddr1    (waddr1),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .raddr     (raddr),
    .rbusy     (rbusy),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, port priority, r0, scoreboard
// set/clear ordering and asynchronous reset.
module tb_regfile_sb;
  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*DW-1:0]   rdata;
  logic [NRD-1:0]      rbusy;
  logic                we0, we1;
  logic [AW-1:0]       waddr0, waddr1;
  logic [DW-1:0]       wdata0, wdata1;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic [NR-1:0]       busy_vec;

  int checks   = 0;
  int failures = 0;

  regfile_sb #(.DATA_W(DW), .NREGS(NR), .NRD(NRD)) dut (
    .clk       (clk),
    .rst       (rst),
    .raddr     (raddr),
    .rdata     (rdata),
    .rbusy     (rbusy),
    .we0       (we0),
    .we1       (we1),
    .waddr0    (waddr0),
    .waddr1    (waddr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy_vec  (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_valid = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; iss_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    rst = 1'b1;
    idle();
    set_ra(5'd4, 5'd0);
    #2;
    chk("reset_busy_vec", busy_vec, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_rbusy", rbusy, 0);
    // Bypass still works in reset; the write itself is discarded.
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'hDEAD_BEEF;
    iss_valid = 1'b1; iss_addr = 5'd4;
    #1;
    chk("reset_bypass", rdata[31:0], 32'hDEAD_BEEF);
    chk("reset_rbusy_iss", rbusy, 0);
    next_cycle();
    idle();
    rst = 1'b0;
    #1;
    chk("reset_write_discarded", rdata[31:0], 0);
    chk("reset_issue_discarded", busy_vec, 0);

    // Single write: bypass then stored
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hA5A5_0001; set_ra(5'd5, 5'd0);
    #1;
    chk("wr5_bypass", rdata[31:0], 32'hA5A5_0001);
    next_cycle();
    idle();
    #1;
    chk("wr5_stored", rdata[31:0], 32'hA5A5_0001);

    // Both ports to r7: load port wins
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    set_ra(5'd7, 5'd7);
    #1;
    chk("r7_bypass_p0", rdata[31:0], 32'h22);
    chk("r7_bypass_p1", rdata[63:32], 32'h22);
    next_cycle();
    idle();
    #1;
    chk("r7_stored", rdata[31:0], 32'h22);

    // r0 ignores writes and issues
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    set_ra(5'd0, 5'd5);
    #1;
    chk("r0_bypass_zero", rdata[31:0], 0);
    chk("r0_rbusy", rbusy, 0);
    next_cycle();
    idle();
    #1;
    chk("r0_read_zero", rdata[31:0], 0);
    chk("r0_not_busy", busy_vec, 0);
    chk("r5_port1", rdata[63:32], 32'hA5A5_0001);

    // r3: issue, wait, then writeback with re-issue in the same cycle
    iss_valid = 1'b1; iss_addr = 5'd3; set_ra(5'd3, 5'd0);
    #1;
    chk("r3_issue_no_same_cycle_busy", rbusy, 0);
    next_cycle();
    idle();
    #1;
    chk("r3_busy_after_issue", busy_vec, 32'h0000_0008);
    chk("r3_rbusy", rbusy, 2'b01);
    next_cycle();
    next_cycle();
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h3333;
    iss_valid = 1'b1; iss_addr = 5'd3;
    #1;
    chk("r3_rbusy_cleared_same_cycle", rbusy, 0);
    chk("r3_bypass", rdata[31:0], 32'h3333);
    chk("r3_busy_vec_no_bypass", busy_vec, 32'h0000_0008);
    next_cycle();
    idle();
    #1;
    chk("r3_set_wins", busy_vec, 32'h0000_0008);
    chk("r3_rbusy_after", rbusy, 2'b01);
    chk("r3_stored", rdata[31:0], 32'h3333);
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3334;
    next_cycle();
    idle();
    #1;
    chk("r3_cleared", busy_vec, 0);

    // r9: issue, then ALU writeback read on port 1
    iss_valid = 1'b1; iss_addr = 5'd9; set_ra(5'd0, 5'd9);
    next_cycle();
    idle();
    #1;
    chk("r9_busy", busy_vec, 32'h0000_0200);
    chk("r9_rbusy1", rbusy, 2'b10);
    next_cycle();
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h9999_0009;
    #1;
    chk("r9_rbusy1_clear", rbusy, 0);
    chk("r9_rdata1_bypass", rdata[63:32], 32'h9999_0009);
    next_cycle();
    idle();
    #1;
    chk("r9_busy_cleared", busy_vec, 0);
    chk("r9_stored", rdata[63:32], 32'h9999_0009);

    // Build busy 0xF00 with r10 = 0x55, then async reset mid-cycle
    we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h55;
    next_cycle();
    idle();
    for (int r = 8; r < 12; r++) begin
      iss_valid = 1'b1; iss_addr = 5'(r);
      next_cycle();
    end
    idle();
    set_ra(5'd10, 5'd5);
    #1;
    chk("pre_rst_busy", busy_vec, 32'h0000_0F00);
    chk("pre_rst_r10", rdata[31:0], 32'h55);
    chk("pre_rst_rbusy", rbusy, 2'b01);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy_vec, 0);
    chk("async_rst_r10", rdata[31:0], 0);
    chk("async_rst_r5", rdata[63:32], 0);
    chk("async_rst_rbusy", rbusy, 0);
    rst = 1'b0;
    we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h77;
    iss_valid = 1'b1; iss_addr = 5'd6;
    set_ra(5'd2, 5'd6);
    next_cycle();
    idle();
    #1;
    chk("post_rst_write", rdata[31:0], 32'h77);
    chk("post_rst_issue", busy_vec, 32'h0000_0040);
    chk("post_rst_rbusy", rbusy, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32: register width in bits.
REQ-002 The block SHALL provide parameter NREGS, default 32: register count, a power of two and at least 4.
REQ-003 The block SHALL provide parameter NRD, default 2: number of read ports, 1 to 4.
REQ-004 The block SHALL provide derived localparam AW = log2(NREGS).
REQ-005 The block SHALL have the following ports.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- raddr  in  NRD*AW  read addresses, port k at [k*AW +: AW].
- rdata  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
- rbusy  out  NRD  port k register has an outstanding producer.
- we0, we1  in  1  write enables; port 0 carries ALU results, port 1 carries load results.
- waddr0, waddr1  in  AW  write addresses.
- wdata0, wdata1  in  DATA_W  write data.
- iss_valid  in  1  issue of an instruction that will write iss_addr.
- iss_addr  in  AW  destination register being reserved.
- busy_vec  out  NREGS  current scoreboard bits.

Function
REQ-006 Register 0 SHALL read as zero, ignore writes, and never become busy.
REQ-007 Reads SHALL be combinational: rdata(k) is the register contents at raddr(k).
REQ-008 Reads SHALL bypass writes: if raddr(k) matches an enabled same-cycle write to a non-zero address, rdata(k) SHALL equal that write's data.
REQ-009 When both write ports target the same non-zero address in one cycle, port 1 SHALL win for both storage and bypass.
REQ-010 Writes SHALL take effect on the rising edge of clk, with a latency of 1 cycle to storage.
REQ-011 An enabled write to register r SHALL clear busy[r] at the same edge.
REQ-012 iss_valid with iss_addr = r, r non-zero, SHALL set busy[r] at the next edge.
REQ-013 A set and a clear of the same register in the same cycle SHALL leave busy set, because the newer producer wins.
REQ-014 A second issue to an already-busy register SHALL keep it busy; there is no count of producers.
REQ-015 rbusy(k) SHALL be combinational and equal to busy[raddr(k)] AND NOT (a clearing write to raddr(k) this cycle).
REQ-016 An issue in the current cycle SHALL NOT affect rbusy in that same cycle.
REQ-017 busy_vec SHALL reflect registered state only, with no bypass.
REQ-018 Out-of-range addresses cannot occur, because AW exactly spans NREGS.

Reset
REQ-019 Asserting rst SHALL immediately clear every register and every busy bit.
REQ-020 While rst is asserted, rdata SHALL still bypass write data, and rbusy SHALL be 0.
REQ-021 Writes and issues during reset SHALL be discarded.
REQ-022 Deassertion of rst SHALL be synchronised externally; the first edge after release SHALL operate normally.

Structure
REQ-023 DATA_W and NREGS defaults and the port-0/port-1 role constants SHALL live in shared package regfile_pkg.
REQ-024 The scoreboard (busy bits with set and clear logic) SHALL be sub-module rf_scoreboard.
REQ-025 Storage, bypass and read muxing SHALL remain in regfile_sb.
REQ-026 The read path SHALL be generated per read port, with no per-port hand-duplication.

Verification
REQ-027 The bench SHALL cover: reset, then we0=1, waddr0=5, wdata0=32'hA5A5_0001, with raddr0=5 in the same cycle -> rdata0=32'hA5A5_0001 (bypass) and on the next cycle (stored).
REQ-028 The bench SHALL cover: we0 and we1 both to register 7 with 32'h11 and 32'h22 -> same-cycle rdata=32'h22, stored value 32'h22.
REQ-029 The bench SHALL cover: we0=1, waddr0=0, wdata0=32'hFFFF_FFFF and iss_valid with iss_addr=0 -> rdata for address 0 = 0, busy_vec[0]=0.
REQ-030 The bench SHALL cover: issue r3 at cycle 1, then we1 to r3 at cycle 4 with iss_valid to r3 in the same cycle -> busy[3]=1 after cycle 4; rbusy at cycle 4 = 0; the data is stored.
REQ-031 The bench SHALL cover: issue r9, then we0 to r9 at cycle 3 with raddr1=9 -> rbusy1=0 and rdata1=wdata0 at cycle 3, busy_vec[9]=0 afterward.
REQ-032 The bench SHALL cover: rst asserted mid-cycle with busy_vec=32'h0000_0F00 and r10=32'h55 -> busy_vec=0 and r10 reads 0 immediately, with no clock edge required.
